ft_recovery_loader: RTL and testbench
=====================================

# ft_recovery_loader

Recovery-side initiator of the fault-tolerance safe-memory data interface. When the lockstep controller asserts recovery, this block reads the checkpointed register file and PC back out of the safe memory, one word per transaction, and replays them into the cores' register-file write port and PC-restore port. It signals completion on `done_o`, which drives the controller's recovery-done input. It is the read-back counterpart of the comparator-gated checkpoint writes.

## Interface
- `ADDR_WIDTH`, 5: register-file address width
- `DATA_WIDTH`, 32: data word width
- `NUM_REGS`, 32: register-file entries; entry 0 is never restored
- `BASE_ADDR`, 32'h0000_0000: byte address of register entry 0 in safe memory
- `MAX_RETRY`, 2: re-issues allowed per word after `err_i`

- `clk_i` in 1: clock
- `rst_ni` in 1: asynchronous, active-low reset
- `start_i` in 1: recovery request (level or pulse); sampled only in IDLE
- `req_o` out 1: memory request
- `gnt_i` in 1: memory grant
- `addr_o` out 32: byte address; stable while `req_o && !gnt_i`
- `we_o` out 1: constant 0 (read-only master)
- `be_o` out 4: constant 4'hF
- `rvalid_i` in 1: read response valid
- `rdata_i` in 32: read data
- `err_i` in 1: response error; qualified by `rvalid_i`
- `rf_we_o` out 1: register-file write strobe
- `rf_addr_o` out ADDR_WIDTH: register-file write address
- `rf_data_o` out DATA_WIDTH: register-file write data
- `pc_o` out DATA_WIDTH: restored PC; holds until the next restore
- `pc_valid_o` out 1: one-cycle pulse when `pc_o` is updated
- `busy_o` out 1: high from the first request through the `done_o` cycle
- `done_o` out 1: one-cycle completion pulse
- `error_o` out 1: sticky retry-exhaustion flag; cleared on the next accepted start

## Operation
- Word sequence: register entries 1..NUM_REGS-1 at `BASE_ADDR + 4*k`, then the PC at `BASE_ADDR + 4*NUM_REGS`. Total words W = NUM_REGS (32 with default parameters).
- FSM states:
  - IDLE: `start_i` goes to REQ and clears `error_o` and the retry count.
  - REQ: `req_o`=1; on `gnt_i`, go to WAIT.
  - WAIT: on `rvalid_i`, go to REQ for the next word, or to DONE after the last word.
  - DONE: pulse `done_o`, then go to IDLE.
- Exactly one outstanding transaction. `rvalid_i` outside WAIT is ignored.
- Good response (`rvalid_i && !err_i`):
  - Register word: next cycle `rf_we_o`=1 for one cycle, with `rf_addr_o`=k and `rf_data_o`=rdata.
  - PC word: next cycle `pc_o`=rdata and `pc_valid_o`=1.
- Error response: re-issue the same address; the retry counter increments.
  - Once retries exceed MAX_RETRY: set `error_o`, skip that word (no write), reset the counter, and continue.
  - Retries are counted per word.
- The word counter is $clog2(NUM_REGS+1) bits wide and never wraps; the terminal compare is against the PC index.
- `start_i` while busy is ignored, with no restart.

## Timing
- Reset values: all outputs 0 except `be_o`=4'hF; state IDLE; counters 0.
- Reset mid-operation aborts immediately. An in-flight response arriving after reset is ignored.
- `start_i` accepted in cycle 0 gives `req_o`=1 in cycle 1.
- `req_o` drops the cycle after `gnt_i`. A grant in the same cycle as `req_o` rise is legal.
- A response in cycle t gives the RF/PC write in t+1, with the next `req_o` also in t+1 (back-to-back).
- Zero-wait memory (same-cycle grant, response one cycle later):
  - Word i requested in cycle 1+2i, response in cycle 2+2i.
  - Last response in cycle 64; `done_o` in cycle 65 with default parameters.
- Wait states stretch timing linearly. `addr_o` holds while `req_o` is high and ungranted.
- `done_o` coincides with the `pc_valid_o` pulse (or with the skipped-PC cycle). `busy_o` falls the cycle after `done_o`.

## Structure
- Shared package `ft_pkg`:
  - `ft_rl_state_e` (IDLE, REQ, WAIT, DONE)
  - `FT_WORD_BYTES`=4
  - PC-slot offset helper constant
- A single module. No sub-module is natural: the FSM, word counter, retry counter and output registers stay together.

## Test plan
- Zero-wait memory returning rdata=32'hA000_0000+k: `rf_we_o` pulses for k=1..31 with matching data, `pc_o`=32'hA000_0020 (the PC word, rdata for k=32), `done_o` in cycle 65, `error_o`=0.
- Grant delayed 3 cycles on word 5: `addr_o`=BASE+20 held stable all 3 cycles, and exactly one `rf_we_o` for entry 5.
- `err_i` twice on word 7, then good: two re-issues of BASE+28, entry 7 written once, `error_o`=0.
- `err_i` three times on word 7 (MAX_RETRY=2): `error_o`=1, no write to entry 7, entries 8..31 and PC still restored, and `done_o` still pulses.
- `start_i` pulsed again mid-sequence: ignored, with exactly 31 RF writes and one `done_o`.
- `rst_ni` low during word 10 WAIT, then start again: outputs at reset values, and the sequence restarts from entry 1.

Source files
------------

// File: rtl/ft_pkg.sv
// Shared definitions for the fault-tolerance safe-memory path.
//   ft_rl_state_e   : recovery-loader FSM states
//   FT_WORD_BYTES   : bytes per safe-memory word
//   ft_slot_offset  : byte offset of word slot idx (PC slot is idx = NUM_REGS)
package ft_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } ft_rl_state_e;

  localparam int unsigned FT_WORD_BYTES = 4;

  // PC slot offset for the default 32-entry register file.
  localparam logic [31:0] FT_DEFAULT_PC_OFFSET = 32'(32 * FT_WORD_BYTES);

  function automatic logic [31:0] ft_slot_offset(input int unsigned idx);
    return 32'(idx * FT_WORD_BYTES);
  endfunction

endpackage

// File: rtl/ft_recovery_loader_if.sv
// Safe-memory data bus between the recovery loader (master) and the
// safe memory (slave). One word per transaction, one outstanding request.
//   req_o/gnt_i      : request / grant handshake
//   addr_o           : byte address, stable while req_o && !gnt_i
//   we_o/be_o        : write enable / byte enables
//   rvalid_i/rdata_i : read response
//   err_i            : response error, qualified by rvalid_i
interface ft_recovery_loader_if;

  logic        req_o;
  logic        gnt_i;
  logic [31:0] addr_o;
  logic        we_o;
  logic [3:0]  be_o;
  logic        rvalid_i;
  logic [31:0] rdata_i;
  logic        err_i;

  modport master (
    output req_o, addr_o, we_o, be_o,
    input  gnt_i, rvalid_i, rdata_i, err_i
  );

  modport slave (
    input  req_o, addr_o, we_o, be_o,
    output gnt_i, rvalid_i, rdata_i, err_i
  );

endinterface

// File: rtl/ft_recovery_loader.sv
// Recovery loader: on start, reads register entries 1..NUM_REGS-1 and then
// the PC back from safe memory and replays them into the register-file write
// port and the PC-restore port. Error responses are retried up to MAX_RETRY
// times per word; a word that still fails is skipped and error_o is set.
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   start_i              : recovery request, sampled in IDLE only
//   mem                  : safe-memory bus (master side)
//   rf_we_o/addr/data    : register-file write port
//   pc_o, pc_valid_o     : restored PC and its update pulse
//   busy_o, done_o       : activity level and completion pulse
//   error_o              : sticky retry-exhaustion flag
module ft_recovery_loader
  import ft_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned MAX_RETRY  = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  ft_recovery_loader_if.master        mem,
  output logic                        rf_we_o,
  output logic [ADDR_WIDTH-1:0]       rf_addr_o,
  output logic [DATA_WIDTH-1:0]       rf_data_o,
  output logic [DATA_WIDTH-1:0]       pc_o,
  output logic                        pc_valid_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        error_o
);

  localparam int unsigned CNT_W = $clog2(NUM_REGS + 1);
  localparam int unsigned RTY_W = $clog2(MAX_RETRY + 2);
  localparam logic [CNT_W-1:0] PC_IDX  = CNT_W'(NUM_REGS);
  localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);

  ft_rl_state_e     state_q, state_d;
  logic [CNT_W-1:0] word_q, word_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic             error_q, error_d;

  logic last_word;
  logic rsp_good;

  // The word counter walks 1..NUM_REGS; the final index is the PC slot.
  assign last_word = (word_q == PC_IDX);
  assign rsp_good  = (state_q == WAIT) && mem.rvalid_i && !mem.err_i;

  // ---- state / counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      word_q  <= '0;
      retry_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      retry_q <= retry_d;
      error_q <= error_d;
    end
  end

  // ---- next-state logic
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    retry_d = retry_q;
    error_d = error_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = REQ;
          word_d  = CNT_W'(1);
          retry_d = '0;
          error_d = 1'b0;
        end
      end
      REQ: begin
        if (mem.gnt_i) state_d = WAIT;
      end
      WAIT: begin
        if (mem.rvalid_i) begin
          if (mem.err_i && (retry_q != RTY_MAX)) begin
            // Re-issue the same address; word_q is unchanged.
            retry_d = retry_q + RTY_W'(1);
            state_d = REQ;
          end else begin
            // Good data, or retries exhausted: either way move past this word.
            if (mem.err_i) error_d = 1'b1;
            retry_d = '0;
            if (last_word) begin
              state_d = DONE;
            end else begin
              word_d  = word_q + CNT_W'(1);
              state_d = REQ;
            end
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- state-decoded outputs
  always_comb begin
    mem.req_o  = 1'b0;
    mem.addr_o = '0;
    busy_o     = 1'b1;
    done_o     = 1'b0;
    unique case (state_q)
      IDLE: busy_o = 1'b0;
      REQ: begin
        mem.req_o  = 1'b1;
        mem.addr_o = BASE_ADDR + ft_slot_offset(32'(word_q));
      end
      WAIT: ;
      DONE: done_o = 1'b1;
      default: busy_o = 1'b0;
    endcase
  end

  assign mem.we_o = 1'b0;
  assign mem.be_o = 4'hF;
  assign error_o  = error_q;

  // ---- response capture: one cycle after a good response
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we_o    <= 1'b0;
      rf_addr_o  <= '0;
      rf_data_o  <= '0;
      pc_o       <= '0;
      pc_valid_o <= 1'b0;
    end else begin
      rf_we_o    <= 1'b0;
      pc_valid_o <= 1'b0;
      if (rsp_good) begin
        if (last_word) begin
          pc_o       <= DATA_WIDTH'(mem.rdata_i);
          pc_valid_o <= 1'b1;
        end else begin
          rf_we_o   <= 1'b1;
          rf_addr_o <= ADDR_WIDTH'(word_q);
          rf_data_o <= DATA_WIDTH'(mem.rdata_i);
        end
      end
    end
  end

endmodule

// File: tb/tb_ft_recovery_loader.sv
module tb_ft_recovery_loader;
  import ft_pkg::*;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          NREGS = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [31:0] pc;
  logic        pc_valid;
  logic        busy;
  logic        done;
  logic        error;

  ft_recovery_loader_if mem ();

  ft_recovery_loader #(
    .ADDR_WIDTH (5),
    .DATA_WIDTH (32),
    .NUM_REGS   (NREGS),
    .BASE_ADDR  (BASE),
    .MAX_RETRY  (2)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .mem        (mem),
    .rf_we_o    (rf_we),
    .rf_addr_o  (rf_addr),
    .rf_data_o  (rf_data),
    .pc_o       (pc),
    .pc_valid_o (pc_valid),
    .busy_o     (busy),
    .done_o     (done),
    .error_o    (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard
  typedef struct { logic [4:0] a; logic [31:0] d; } rf_exp_t;
  typedef struct { int rel; logic err; logic pcv; } done_exp_t;
  rf_exp_t     rf_q[$];
  logic [31:0] pc_q[$];
  done_exp_t   done_q[$];
  int          start_cyc = 0;
  int          done_cnt  = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rf_we) begin
          if (rf_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL rf_unexpected: got write addr %0d data %h expected none", rf_addr, rf_data);
          end else begin
            rf_exp_t e;
            e = rf_q.pop_front();
            check("rf_addr", 32'(rf_addr), 32'(e.a));
            check("rf_data", rf_data, e.d);
          end
        end
        if (pc_valid) begin
          if (pc_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL pc_unexpected: got pc %h expected none", pc);
          end else begin
            check("pc_value", pc, pc_q.pop_front());
          end
        end
        if (done) begin
          done_cnt++;
          if (done_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL done_unexpected: got done_o=1 expected 0");
          end else begin
            done_exp_t de;
            de = done_q.pop_front();
            if (de.rel >= 0) check("done_cycle", 32'(cyc - start_cyc), 32'(de.rel));
            check("done_error", 32'(error), 32'(de.err));
            check("done_pc_valid", 32'(pc_valid), 32'(de.pcv));
            check("done_busy", 32'(busy), 32'd1);
          end
        end
      end
    end
  end

  // ---------------- memory model
  int          gnt_delay[0:NREGS];
  int          err_n[0:NREGS];
  int          issues[0:NREGS];
  bit          pend = 1'b0;
  int          pend_k = 0;
  bit          pend_err = 1'b0;
  int          wait_n = 0;
  bit          held = 1'b0;
  logic [31:0] held_addr = '0;

  initial begin
    mem.gnt_i    = 1'b0;
    mem.rvalid_i = 1'b0;
    mem.rdata_i  = '0;
    mem.err_i    = 1'b0;
    forever begin
      @(negedge clk);
      mem.gnt_i    = 1'b0;
      mem.rvalid_i = 1'b0;
      mem.err_i    = 1'b0;
      mem.rdata_i  = '0;
      if (pend) begin
        mem.rvalid_i = 1'b1;
        mem.err_i    = pend_err;
        mem.rdata_i  = pend_err ? 32'hDEAD_BEEF : 32'hA000_0000 + 32'(pend_k);
        pend = 1'b0;
      end
      if (mem.req_o && rst_n) begin
        int k;
        k = int'((mem.addr_o - BASE) >> 2);
        if (held) check("addr_stable", mem.addr_o, held_addr);
        if (k < 0 || k > NREGS) begin
          n_tests++; n_fail++;
          $display("FAIL addr_range: got %h expected within safe-memory window", mem.addr_o);
          k = 0;
        end
        if (wait_n < gnt_delay[k]) begin
          wait_n++;
          held      = 1'b1;
          held_addr = mem.addr_o;
        end else begin
          mem.gnt_i = 1'b1;
          pend      = 1'b1;
          pend_k    = k;
          pend_err  = (issues[k] < err_n[k]);
          issues[k]++;
          wait_n    = 0;
          held      = 1'b0;
        end
      end else begin
        held   = 1'b0;
        wait_n = 0;
      end
    end
  end

  // ---------------- stimulus helpers
  task automatic clear_cfg();
    for (int i = 0; i <= NREGS; i++) begin
      gnt_delay[i] = 0;
      err_n[i]     = 0;
      issues[i]    = 0;
    end
  endtask

  task automatic push_all(input int skip_k, input logic exp_err, input int exp_rel);
    for (int k = 1; k < NREGS; k++)
      if (k != skip_k) rf_q.push_back('{a: 5'(k), d: 32'hA000_0000 + 32'(k)});
    if (skip_k != NREGS) pc_q.push_back(32'hA000_0020);
    done_q.push_back('{rel: exp_rel, err: exp_err, pcv: (skip_k != NREGS)});
  endtask

  task automatic run_seq(input string tag, input bit chk_start, input int repulse_at);
    int n;
    int d0;
    d0 = done_cnt;
    @(posedge clk); #1;
    start     = 1'b1;
    start_cyc = cyc;
    if (chk_start) check({tag, "_req_c0"}, 32'(mem.req_o), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    if (chk_start) begin
      check({tag, "_req_c1"}, 32'(mem.req_o), 32'd1);
      check({tag, "_busy_c1"}, 32'(busy), 32'd1);
      check({tag, "_err_clr"}, 32'(error), 32'd0);
    end
    n = 1;
    while (done_cnt == d0 && n < 600) begin
      @(posedge clk); #1;
      n++;
      if (repulse_at > 0 && n == repulse_at) start = 1'b1;
      else start = 1'b0;
    end
    start = 1'b0;
    if (done_cnt == d0) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: got no done_o expected done_o within 600 cycles", tag);
    end
    repeat (6) @(posedge clk);
    #1;
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_rf_left"}, 32'(rf_q.size()), 32'd0);
    check({tag, "_pc_left"}, 32'(pc_q.size()), 32'd0);
    check({tag, "_done_left"}, 32'(done_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, 32'(mem.req_o), 32'd0);
    check({tag, "_addr"}, mem.addr_o, 32'd0);
    check({tag, "_we"}, 32'(mem.we_o), 32'd0);
    check({tag, "_be"}, 32'(mem.be_o), 32'hF);
    check({tag, "_rf_we"}, 32'(rf_we), 32'd0);
    check({tag, "_rf_addr"}, 32'(rf_addr), 32'd0);
    check({tag, "_rf_data"}, rf_data, 32'd0);
    check({tag, "_pc"}, pc, 32'd0);
    check({tag, "_pc_valid"}, 32'(pc_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  // ---------------- directed tests
  initial begin
    int n;
    clear_cfg();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst0");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Zero-wait sequence, done in cycle 65.
    clear_cfg();
    push_all(0, 1'b0, 65);
    run_seq("zw", 1'b1, 0);
    check("zw_pc_hold", pc, 32'hA000_0020);

    // Grant delayed 3 cycles on word 5.
    clear_cfg();
    gnt_delay[5] = 3;
    push_all(0, 1'b0, 68);
    run_seq("gd", 1'b0, 0);
    check("gd_issues5", 32'(issues[5]), 32'd1);

    // Two errors on word 7, then good data.
    clear_cfg();
    err_n[7] = 2;
    push_all(0, 1'b0, 69);
    run_seq("e2", 1'b0, 0);
    check("e2_issues7", 32'(issues[7]), 32'd3);

    // Three errors on word 7: skipped, error flagged, rest still restored.
    clear_cfg();
    err_n[7] = 3;
    push_all(7, 1'b1, 69);
    run_seq("e3", 1'b0, 0);
    check("e3_issues7", 32'(issues[7]), 32'd3);
    check("e3_error_sticky", 32'(error), 32'd1);

    // Error on the PC word exhausted: PC skipped, done still pulses.
    clear_cfg();
    err_n[NREGS] = 3;
    push_all(NREGS, 1'b1, 69);
    run_seq("epc", 1'b0, 0);

    // Start re-pulsed mid-sequence is ignored; error_o cleared on accepted start.
    clear_cfg();
    push_all(0, 1'b0, 65);
    run_seq("rp", 1'b1, 25);
    check("rp_issues1", 32'(issues[1]), 32'd1);

    // Reset during the WAIT of word 10, then restart from entry 1.
    clear_cfg();
    push_all(0, 1'b0, 65);
    @(posedge clk); #1;
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(mem.req_o && mem.addr_o == BASE + 32'd40) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rs_reach_w10", 32'(mem.addr_o), BASE + 32'd40);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rs");
    rf_q.delete();
    pc_q.delete();
    done_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check("rs_idle_after_rsp", 32'(busy), 32'd0);
    check("rs_no_rf_write", 32'(rf_we), 32'd0);
    clear_cfg();
    push_all(0, 1'b0, 65);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run_seq("rs2", 1'b1, 0);
    check("rs2_issues1", 32'(issues[1]), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
